// File: rtl/tagged_table_pkg.sv
// Shared branch-predictor types for the tagged prediction tables.
// The typedefs describe the default table geometry; parametrised instances derive their own.
package bpu_pkg;

    localparam int DEF_DEPTH_EXP2   = 10;
    localparam int DEF_TAG_WIDTH    = 8;
    localparam int DEF_CTR_WIDTH    = 3;
    localparam int DEF_USEFUL_WIDTH = 2;

    typedef struct packed {
        logic [DEF_DEPTH_EXP2-1:0] index;
        logic [DEF_TAG_WIDTH-1:0]  tag;
    } tagged_meta_t;

    typedef struct packed {
        logic                        valid;
        logic [DEF_TAG_WIDTH-1:0]    tag;
        logic [DEF_CTR_WIDTH-1:0]    ctr;
        logic [DEF_USEFUL_WIDTH-1:0] useful;
    } tagged_entry_t;

    // Weakly-taken value of a direction counter: only the MSB set.
    function automatic int unsigned weak_ctr(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/tagged_table_if.sv
// Query/response and update port bundle of one tagged prediction table.
// master = predictor control, slave = the table.
interface tagged_table_if #(
    parameter int GHR_LENGTH   = 16,
    parameter int PC_WIDTH     = 32,
    parameter int DEPTH_EXP2   = 10,
    parameter int TAG_WIDTH    = 8,
    parameter int CTR_WIDTH    = 3,
    parameter int USEFUL_WIDTH = 2
);
    logic                            query_valid_i;
    logic [PC_WIDTH-1:0]             pc_i;
    logic [GHR_LENGTH-1:0]           global_history_i;
    logic                            resp_valid_o;
    logic                            taken_o;
    logic                            tag_hit_o;
    logic [CTR_WIDTH-1:0]            ctr_o;
    logic [USEFUL_WIDTH-1:0]         useful_o;
    logic [DEPTH_EXP2+TAG_WIDTH-1:0] meta_o;
    logic                            update_valid_i;
    logic [DEPTH_EXP2+TAG_WIDTH-1:0] update_meta_i;
    logic                            update_taken_i;
    logic                            update_provider_i;
    logic                            update_alloc_i;
    logic                            update_useful_inc_i;
    logic                            update_useful_dec_i;

    modport master (
        output query_valid_i, pc_i, global_history_i,
        output update_valid_i, update_meta_i, update_taken_i, update_provider_i,
        output update_alloc_i, update_useful_inc_i, update_useful_dec_i,
        input  resp_valid_o, taken_o, tag_hit_o, ctr_o, useful_o, meta_o
    );

    modport slave (
        input  query_valid_i, pc_i, global_history_i,
        input  update_valid_i, update_meta_i, update_taken_i, update_provider_i,
        input  update_alloc_i, update_useful_inc_i, update_useful_dec_i,
        output resp_valid_o, taken_o, tag_hit_o, ctr_o, useful_o, meta_o
    );

endinterface

// File: rtl/tagged_table_history_fold.sv
// Combinational history folding: XOR of consecutive OUT_LEN-bit slices,
// the last slice zero-padded.
module history_fold #(
    parameter int IN_LEN  = 16,
    parameter int OUT_LEN = 8
) (
    input  logic [IN_LEN-1:0]  history,
    output logic [OUT_LEN-1:0] folded
);
    localparam int N_SLICES = (IN_LEN + OUT_LEN - 1) / OUT_LEN;
    localparam int PAD_W    = N_SLICES * OUT_LEN;

    logic [PAD_W-1:0] padded;

    assign padded = PAD_W'(history);

    always_comb begin
        folded = '0;
        for (int s = 0; s < N_SLICES; s++) begin
            folded = folded ^ padded[s*OUT_LEN +: OUT_LEN];
        end
    end

endmodule

// File: rtl/tagged_table.sv
// Tagged TAGE component table: registered query with folded-history index/tag,
// meta-addressed updates, saturating counters and periodic useful decay.
module tagged_table
    import bpu_pkg::*;
#(
    parameter int GHR_LENGTH        = 16,
    parameter int PC_WIDTH          = 32,
    parameter int DEPTH_EXP2        = 10,
    parameter int TAG_WIDTH         = 8,
    parameter int CTR_WIDTH         = 3,
    parameter int USEFUL_WIDTH      = 2,
    parameter int DECAY_PERIOD_EXP2 = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    tagged_table_if.slave bus
);
    localparam int DEPTH  = 1 << DEPTH_EXP2;
    localparam int META_W = DEPTH_EXP2 + TAG_WIDTH;

    localparam logic [CTR_WIDTH-1:0]    CTR_WEAK_T = CTR_WIDTH'(weak_ctr(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0]    CTR_WEAK_N = CTR_WEAK_T - 1'b1;
    localparam logic [CTR_WIDTH-1:0]    CTR_MAX    = '1;
    localparam logic [USEFUL_WIDTH-1:0] USE_MAX    = '1;

    typedef struct packed {
        logic                    valid;
        logic [TAG_WIDTH-1:0]    tag;
        logic [CTR_WIDTH-1:0]    ctr;
        logic [USEFUL_WIDTH-1:0] useful;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, ctr: CTR_WEAK_T, useful: '0};

    entry_t table_q [DEPTH];

    logic [DECAY_PERIOD_EXP2-1:0] decay_cnt;

    logic                    resp_valid_q;
    logic                    taken_q;
    logic                    hit_q;
    logic [CTR_WIDTH-1:0]    ctr_q;
    logic [USEFUL_WIDTH-1:0] useful_q;
    logic [META_W-1:0]       meta_q;

    // Query index/tag
    logic [DEPTH_EXP2-1:0] fold_idx;
    logic [TAG_WIDTH-1:0]  fold_tag;
    logic [TAG_WIDTH-2:0]  fold_tag_s;
    logic [DEPTH_EXP2-1:0] q_idx;
    logic [TAG_WIDTH-1:0]  q_tag;
    entry_t                q_entry;
    logic                  unused_pc;

    history_fold #(.IN_LEN(GHR_LENGTH), .OUT_LEN(DEPTH_EXP2)) u_fold_idx (
        .history (bus.global_history_i),
        .folded  (fold_idx)
    );

    history_fold #(.IN_LEN(GHR_LENGTH), .OUT_LEN(TAG_WIDTH)) u_fold_tag (
        .history (bus.global_history_i),
        .folded  (fold_tag)
    );

    history_fold #(.IN_LEN(GHR_LENGTH), .OUT_LEN(TAG_WIDTH-1)) u_fold_tag_s (
        .history (bus.global_history_i),
        .folded  (fold_tag_s)
    );

    assign q_idx     = bus.pc_i[DEPTH_EXP2+1:2] ^ fold_idx;
    assign q_tag     = bus.pc_i[TAG_WIDTH+1:2] ^ fold_tag ^ {fold_tag_s, 1'b0};
    assign q_entry   = table_q[q_idx];
    assign unused_pc = ^bus.pc_i;

    // Update decode
    logic [DEPTH_EXP2-1:0]   u_idx;
    logic [TAG_WIDTH-1:0]    u_tag;
    entry_t                  u_entry;
    logic                    u_hit;
    logic                    do_alloc;
    logic                    do_train;
    logic                    do_useful;
    logic                    decay_wrap;
    logic [CTR_WIDTH-1:0]    ctr_next;
    logic [USEFUL_WIDTH-1:0] useful_next;

    assign u_idx      = bus.update_meta_i[META_W-1:TAG_WIDTH];
    assign u_tag      = bus.update_meta_i[TAG_WIDTH-1:0];
    assign u_entry    = table_q[u_idx];
    assign u_hit      = u_entry.valid && (u_entry.tag == u_tag);
    assign do_alloc   = bus.update_valid_i && bus.update_alloc_i;
    assign do_train   = bus.update_valid_i && bus.update_provider_i && !bus.update_alloc_i && u_hit;
    assign do_useful  = do_train && (bus.update_useful_inc_i != bus.update_useful_dec_i);
    assign decay_wrap = bus.update_valid_i && (decay_cnt == '1);

    always_comb begin
        ctr_next = u_entry.ctr;
        if (bus.update_taken_i && u_entry.ctr != CTR_MAX) begin
            ctr_next = u_entry.ctr + 1'b1;
        end else if (!bus.update_taken_i && u_entry.ctr != '0) begin
            ctr_next = u_entry.ctr - 1'b1;
        end
    end

    always_comb begin
        useful_next = u_entry.useful;
        if (bus.update_useful_inc_i && u_entry.useful != USE_MAX) begin
            useful_next = u_entry.useful + 1'b1;
        end else if (bus.update_useful_dec_i && u_entry.useful != '0) begin
            useful_next = u_entry.useful - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= RESET_ENTRY;
            end
            decay_cnt    <= '0;
            resp_valid_q <= 1'b0;
            taken_q      <= 1'b0;
            hit_q        <= 1'b0;
            ctr_q        <= '0;
            useful_q     <= '0;
            meta_q       <= '0;
        end else begin
            resp_valid_q <= bus.query_valid_i;
            if (bus.query_valid_i) begin
                taken_q  <= q_entry.ctr[CTR_WIDTH-1];
                hit_q    <= q_entry.valid && (q_entry.tag == q_tag);
                ctr_q    <= q_entry.ctr;
                useful_q <= q_entry.useful;
                meta_q   <= {q_idx, q_tag};
            end

            if (bus.update_valid_i) begin
                decay_cnt <= decay_cnt + 1'b1;
            end
            if (decay_wrap) begin
                for (int i = 0; i < DEPTH; i++) begin
                    table_q[i].useful <= table_q[i].useful >> 1;
                end
            end

            // Written after the decay loop so an update's useful value wins.
            if (do_alloc) begin
                table_q[u_idx] <= '{valid: 1'b1, tag: u_tag,
                                    ctr: bus.update_taken_i ? CTR_WEAK_T : CTR_WEAK_N,
                                    useful: '0};
            end else if (do_train) begin
                table_q[u_idx].ctr <= ctr_next;
                if (do_useful) begin
                    table_q[u_idx].useful <= useful_next;
                end
            end
        end
    end

    assign bus.resp_valid_o = resp_valid_q;
    assign bus.taken_o      = taken_q;
    assign bus.tag_hit_o    = hit_q;
    assign bus.ctr_o        = ctr_q;
    assign bus.useful_o     = useful_q;
    assign bus.meta_o       = meta_q;

endmodule

// File: tb/tb_tagged_table.sv
// Self-checking bench for tagged_table: directed scenarios plus randomized
// traffic checked against an integer-array model of the table.
module tb_tagged_table;

    localparam int GHR   = 16;
    localparam int PCW   = 32;
    localparam int DEXP  = 6;
    localparam int TAGW  = 8;
    localparam int CTRW  = 3;
    localparam int USEW  = 2;
    localparam int DECAY = 2;
    localparam int NENT  = 1 << DEXP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tagged_table_if #(.GHR_LENGTH(GHR), .PC_WIDTH(PCW), .DEPTH_EXP2(DEXP),
                      .TAG_WIDTH(TAGW), .CTR_WIDTH(CTRW), .USEFUL_WIDTH(USEW)) bus ();

    tagged_table #(.GHR_LENGTH(GHR), .PC_WIDTH(PCW), .DEPTH_EXP2(DEXP), .TAG_WIDTH(TAGW),
                   .CTR_WIDTH(CTRW), .USEFUL_WIDTH(USEW), .DECAY_PERIOD_EXP2(DECAY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int m_valid [NENT];
    int m_tag   [NENT];
    int m_ctr   [NENT];
    int m_use   [NENT];
    int m_dcnt;

    int exp_taken, exp_hit, exp_ctr, exp_use, exp_meta;
    int meta_q [$];
    int m0;

    // Bit k of the history lands on output bit k mod w.
    function automatic int fold(input logic [15:0] h, input int w);
        int r;
        r = 0;
        for (int k = 0; k < 16; k++) begin
            if (h[k]) r = r ^ (1 << (k % w));
        end
        return r;
    endfunction

    function automatic int m_index(input logic [31:0] pc, input logic [15:0] h);
        return int'(pc[7:2]) ^ fold(h, DEXP);
    endfunction

    function automatic int m_tagof(input logic [31:0] pc, input logic [15:0] h);
        return int'(pc[9:2]) ^ fold(h, TAGW) ^ ((fold(h, TAGW - 1) << 1) & 255);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_ctr[i]   = 4;
            m_use[i]   = 0;
        end
        m_dcnt = 0;
    endtask

    task automatic m_update(input int meta, input bit tk, input bit prov, input bit alloc,
                            input bit inc, input bit dec);
        int  i;
        int  t;
        int  old_use;
        bit  hit;
        bit  wrap;
        i       = (meta >> TAGW) & (NENT - 1);
        t       = meta & 255;
        old_use = m_use[i];
        hit     = (m_valid[i] == 1) && (m_tag[i] == t);
        wrap    = (m_dcnt == (1 << DECAY) - 1);
        m_dcnt  = (m_dcnt + 1) % (1 << DECAY);
        if (wrap) begin
            for (int j = 0; j < NENT; j++) m_use[j] = m_use[j] / 2;
        end
        if (alloc) begin
            m_valid[i] = 1;
            m_tag[i]   = t;
            m_ctr[i]   = tk ? 4 : 3;
            m_use[i]   = 0;
        end else if (prov && hit) begin
            if (tk) m_ctr[i] = (m_ctr[i] == 7) ? 7 : m_ctr[i] + 1;
            else    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            if (inc && !dec)      m_use[i] = (old_use == 3) ? 3 : old_use + 1;
            else if (dec && !inc) m_use[i] = (old_use == 0) ? 0 : old_use - 1;
        end
    endtask

    // Drives one cycle of query and/or update, advances the model, and leaves
    // the bench 1 time unit after the edge with strobes deasserted.
    task automatic do_cycle(input bit qv, input logic [31:0] pc, input logic [15:0] h,
                            input bit uv, input int meta, input bit tk, input bit prov,
                            input bit alloc, input bit inc, input bit dec);
        int i;
        int t;
        bus.query_valid_i       = qv;
        bus.pc_i                = pc;
        bus.global_history_i    = h;
        bus.update_valid_i      = uv;
        bus.update_meta_i       = 14'(meta);
        bus.update_taken_i      = tk;
        bus.update_provider_i   = prov;
        bus.update_alloc_i      = alloc;
        bus.update_useful_inc_i = inc;
        bus.update_useful_dec_i = dec;
        if (qv) begin
            i         = m_index(pc, h);
            t         = m_tagof(pc, h);
            exp_meta  = (i << TAGW) | t;
            exp_ctr   = m_ctr[i];
            exp_use   = m_use[i];
            exp_taken = (m_ctr[i] >= 4) ? 1 : 0;
            exp_hit   = (m_valid[i] == 1 && m_tag[i] == t) ? 1 : 0;
        end
        if (uv) m_update(meta, tk, prov, alloc, inc, dec);
        @(posedge clk);
        #1;
        bus.query_valid_i  = 1'b0;
        bus.update_valid_i = 1'b0;
    endtask

    task automatic query(input logic [31:0] pc, input logic [15:0] h);
        do_cycle(1'b1, pc, h, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic update(input int meta, input bit tk, input bit prov, input bit alloc,
                          input bit inc, input bit dec);
        do_cycle(1'b0, 32'h0, 16'h0, 1'b1, meta, tk, prov, alloc, inc, dec);
    endtask

    task automatic test_reset();
        bus.query_valid_i       = 1'b0;
        bus.pc_i                = '0;
        bus.global_history_i    = '0;
        bus.update_valid_i      = 1'b0;
        bus.update_meta_i       = '0;
        bus.update_taken_i      = 1'b0;
        bus.update_provider_i   = 1'b0;
        bus.update_alloc_i      = 1'b0;
        bus.update_useful_inc_i = 1'b0;
        bus.update_useful_dec_i = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.resp_valid_o, bus.taken_o, bus.tag_hit_o, bus.ctr_o, bus.useful_o, bus.meta_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {bus.resp_valid_o, bus.taken_o, bus.tag_hit_o, bus.ctr_o, bus.useful_o, bus.meta_o});
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        query(32'($urandom), 16'h0);
        n_tests++;
        if (bus.resp_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_query_valid: got %b want 1", bus.resp_valid_o);
        end
        n_tests++;
        if (bus.taken_o !== 1'b1 || bus.tag_hit_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_query_taken_hit: got %b%b want 10", bus.taken_o, bus.tag_hit_o);
        end
        n_tests++;
        if (bus.ctr_o !== 3'd4 || bus.useful_o !== 2'd0) begin
            n_fail++; $display("FAIL reset_query_ctr_use: got %0d/%0d want 4/0", bus.ctr_o, bus.useful_o);
        end
        n_tests++;
        if (bus.meta_o !== 14'(exp_meta)) begin
            n_fail++; $display("FAIL reset_query_meta: got %h want %h", bus.meta_o, exp_meta);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.resp_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL resp_pulse: got %b want 0", bus.resp_valid_o);
        end
    endtask

    task automatic test_alloc();
        query(32'h1000, 16'h0);
        m0 = exp_meta;
        n_tests++;
        if (bus.meta_o !== 14'(exp_meta) || bus.tag_hit_o !== 1'b0) begin
            n_fail++; $display("FAIL alloc_premeta: got %h/%b want %h/0", bus.meta_o, bus.tag_hit_o, exp_meta);
        end
        update(m0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        query(32'h1000, 16'h0);
        n_tests++;
        if (bus.tag_hit_o !== 1'b1 || bus.ctr_o !== 3'd3 || bus.taken_o !== 1'b0) begin
            n_fail++; $display("FAIL alloc_entry: got hit=%b ctr=%0d taken=%b want 1/3/0",
                               bus.tag_hit_o, bus.ctr_o, bus.taken_o);
        end
    endtask

    task automatic test_saturate();
        repeat (5) update(m0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        query(32'h1000, 16'h0);
        n_tests++;
        if (bus.ctr_o !== 3'd7 || bus.taken_o !== 1'b1) begin
            n_fail++; $display("FAIL ctr_saturate: got %0d want 7", bus.ctr_o);
        end
        repeat (4) update(m0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        query(32'h1000, 16'h0);
        n_tests++;
        if (bus.useful_o !== 2'd3 || 32'(bus.useful_o) !== exp_use) begin
            n_fail++; $display("FAIL useful_saturate: got %0d want 3 (model %0d)", bus.useful_o, exp_use);
        end
    endtask

    task automatic test_decay();
        repeat (4) update((5 << TAGW) | 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        query(32'h1000, 16'h0);
        n_tests++;
        if (bus.useful_o !== 2'd1) begin
            n_fail++; $display("FAIL decay_once: got %0d want 1", bus.useful_o);
        end
        repeat (4) update((9 << TAGW) | 8'h12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        query(32'h1000, 16'h0);
        n_tests++;
        if (bus.useful_o !== 2'd0 || bus.ctr_o !== 3'd7) begin
            n_fail++; $display("FAIL decay_twice: got use=%0d ctr=%0d want 0/7", bus.useful_o, bus.ctr_o);
        end
    endtask

    task automatic test_replace();
        update((m0 & ~255) | 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        update(m0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        query(32'h1000, 16'h0);
        n_tests++;
        if (bus.tag_hit_o !== 1'b0 || bus.ctr_o !== 3'd4) begin
            n_fail++; $display("FAIL stale_update: got hit=%b ctr=%0d want 0/4", bus.tag_hit_o, bus.ctr_o);
        end
    endtask

    task automatic test_same_cycle();
        do_cycle(1'b1, 32'h1000, 16'h0, 1'b1, (m0 & ~255) | 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (bus.ctr_o !== 3'd4) begin
            n_fail++; $display("FAIL no_bypass: got %0d want 4", bus.ctr_o);
        end
        query(32'h1000, 16'h0);
        n_tests++;
        if (bus.ctr_o !== 3'd5) begin
            n_fail++; $display("FAIL after_update: got %0d want 5", bus.ctr_o);
        end
    endtask

    task automatic test_random();
        bit          qv, uv, tk, prov, alloc, inc, dec;
        logic [31:0] pc;
        logic [15:0] h;
        int          meta;
        for (int n = 0; n < 400; n++) begin
            qv    = ($urandom_range(0, 3) != 0);
            pc    = 32'($urandom_range(0, 31)) << 2;
            h     = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0;
            uv    = ($urandom_range(0, 1) == 1);
            if (meta_q.size() > 0 && $urandom_range(0, 3) != 0)
                meta = meta_q[$urandom_range(0, meta_q.size() - 1)];
            else
                meta = int'($urandom_range(0, 16383));
            tk    = 1'($urandom);
            prov  = 1'($urandom);
            alloc = ($urandom_range(0, 3) == 0);
            inc   = 1'($urandom);
            dec   = 1'($urandom);
            do_cycle(qv, pc, h, uv, meta, tk, prov, alloc, inc, dec);
            n_tests++;
            if (bus.resp_valid_o !== qv) begin
                n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", n, bus.resp_valid_o, qv);
            end
            if (qv) begin
                meta_q.push_back(exp_meta);
                if (meta_q.size() > 16) void'(meta_q.pop_front());
                n_tests++;
                if (bus.meta_o !== 14'(exp_meta) || bus.ctr_o !== 3'(exp_ctr) ||
                    bus.useful_o !== 2'(exp_use) || bus.tag_hit_o !== 1'(exp_hit) ||
                    bus.taken_o !== 1'(exp_taken)) begin
                    n_fail++;
                    $display("FAIL rand_resp[%0d]: got meta=%h ctr=%0d use=%0d hit=%b tk=%b want %h/%0d/%0d/%0d/%0d",
                             n, bus.meta_o, bus.ctr_o, bus.useful_o, bus.tag_hit_o, bus.taken_o,
                             exp_meta, exp_ctr, exp_use, exp_hit, exp_taken);
                end
            end
        end
    endtask

    task automatic test_midreset();
        query(32'h1000, 16'h0);
        n_tests++;
        if (bus.resp_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL midreset_pre: got %b want 1", bus.resp_valid_o);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (bus.resp_valid_o !== 1'b0 || bus.ctr_o !== 3'd0) begin
            n_fail++; $display("FAIL midreset_drop: got %b/%0d want 0/0", bus.resp_valid_o, bus.ctr_o);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        query(32'h1000, 16'h0);
        n_tests++;
        if (bus.ctr_o !== 3'd4 || bus.tag_hit_o !== 1'b0 || bus.useful_o !== 2'd0) begin
            n_fail++; $display("FAIL midreset_reinit: got ctr=%0d hit=%b use=%0d want 4/0/0",
                               bus.ctr_o, bus.tag_hit_o, bus.useful_o);
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_saturate();
        test_decay();
        test_replace();
        test_same_cycle();
        test_random();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tagged_table.md
# tagged_table

Parametrised tagged prediction table, the successor to the single-table tagged predictor. It is one component of a TAGE-style branch predictor. It provides N-bit saturating direction counters, a per-entry valid bit, and U-bit useful counters with periodic graceful decay. The query path is registered and folds history combinationally. Each query's metadata (index, tag) is returned to the caller, so updates need no PC-matching buffer.

## Interface
- GHR_LENGTH, 16, global history bits consumed
- PC_WIDTH, 32, PC width
- DEPTH_EXP2, 10, log2 of entry count
- TAG_WIDTH, 8, tag bits
- CTR_WIDTH, 3, direction counter bits (≥2)
- USEFUL_WIDTH, 2, useful counter bits (≥1)
- DECAY_PERIOD_EXP2, 12, log2 of updates between useful decays
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- query_valid_i  in  1  query request
- pc_i  in  PC_WIDTH  query PC
- global_history_i  in  GHR_LENGTH  history, bit 0 newest
- resp_valid_o  out  1  response valid
- taken_o  out  1  counter MSB of queried entry
- tag_hit_o  out  1  entry valid and tag equal
- ctr_o  out  CTR_WIDTH  queried counter
- useful_o  out  USEFUL_WIDTH  queried useful counter
- meta_o  out  DEPTH_EXP2+TAG_WIDTH  {index, tag} of query
- update_valid_i  in  1  update strobe
- update_meta_i  in  DEPTH_EXP2+TAG_WIDTH  meta_o captured at query
- update_taken_i  in  1  resolved direction
- update_provider_i  in  1  this table was provider: train counter
- update_alloc_i  in  1  allocate entry at update_meta_i
- update_useful_inc_i / update_useful_dec_i  in  1  useful adjust (provider only)

## Operation
- Index = PC[DEPTH_EXP2+1:2] ^ fold(history, DEPTH_EXP2). Tag = PC[TAG_WIDTH+1:2] ^ fold(history, TAG_WIDTH) ^ (fold(history, TAG_WIDTH-1) << 1). fold is an XOR of consecutive slices of the given width; the last slice is zero-padded.
- Entry: {valid, tag, ctr, useful}. Reset: valid 0, tag 0, ctr 2^(CTR_WIDTH-1) (weak taken), useful 0.
- tag_hit_o requires valid=1; a tag-0 query never hits an invalid entry.
- Allocate (update_alloc_i, overrides provider): valid←1, tag←meta tag, ctr←2^(CTR_WIDTH-1) if taken else 2^(CTR_WIDTH-1)-1, useful←0. Victim choice (useful==0) is made upstream from useful_o.
- Provider train, applied only if stored tag equals meta tag and valid: ctr ±1 saturating at 0 / 2^CTR_WIDTH-1. useful inc/dec saturates. If inc and dec are both asserted, no change. On tag mismatch (entry replaced meanwhile) the update is dropped.
- Decay: a DECAY_PERIOD_EXP2-bit counter counts update_valid_i cycles. On wrap, every useful counter shifts right by 1 in that same cycle. An update's useful write to the same entry in that cycle takes precedence.

## Timing
- Query: 1-cycle latency. Outputs are registered and held until the next query. resp_valid_o pulses one cycle.
- Update: written at the edge ending the update cycle. A query of the same index in that cycle returns pre-update contents (no bypass).
- Back-to-back queries and updates are accepted every cycle, with no stalls.
- Reset: all outputs 0, decay counter 0, table reinitialised. Asserting reset mid-operation discards any in-flight response.

## Structure
- Package bpu_pkg holds tagged_meta_t (packed {index, tag}), tagged_entry_t, and a weak-counter constant function.
- Sub-module history_fold #(IN_LEN, OUT_LEN) is purely combinational and is instantiated three times.
- The table is held as flop arrays so that reset and decay stay simple.

## Test plan
- Post-reset query of any PC, history 0 -> resp_valid_o=1 next cycle, taken_o=1, tag_hit_o=0, ctr_o=4, useful_o=0.
- Allocate PC 0x1000 with taken=0, then query the same PC/history -> tag_hit_o=1, ctr_o=3, taken_o=0.
- Five provider updates taken on that entry -> ctr_o=7 (saturates); useful_inc ×4 -> useful_o=3.
- Reallocate the same index with a different tag, then send a provider update using the old meta -> counter unchanged.
- DECAY_PERIOD_EXP2=2 with useful=3: four updates to other entries -> useful_o=1; four more -> 0.
- Query and update of the same index in one cycle -> old counter is returned; the following query shows the new value.
